// File: rtl/pc_ret_stack.sv
// pc_ret_stack: program counter register plus a hardware return-address LIFO.
// It sits directly after the PC-source select mux. PC_COUNT is loaded from
// the mux output or incremented. CALL/RET push and pop the pre-edge PC.
// STACK_TOP feeds back to the mux FROM_STACK input.
//
// Ports:
//   CLK, RST          rising-edge clock; synchronous active-high reset
//   D_IN              next address from the PC-source mux
//   PC_LD, PC_INC     PC update controls (load has priority over increment)
//   PUSH, POP         return-stack controls (CALL / RET)
//   PC_COUNT          registered program counter
//   STACK_TOP         current top entry, or 0 when the stack is empty
//   STACK_EMPTY/FULL  occupancy flags
//   STACK_ERR         sticky overflow/underflow flag, cleared only by reset
module pc_ret_stack #(
  parameter int n     = 10,
  parameter int DEPTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [n-1:0] D_IN,
  input  logic         PC_LD,
  input  logic         PC_INC,
  input  logic         PUSH,
  input  logic         POP,
  output logic [n-1:0] PC_COUNT,
  output logic [n-1:0] STACK_TOP,
  output logic         STACK_EMPTY,
  output logic         STACK_FULL,
  output logic         STACK_ERR
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [n-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp, sp_nxt;
  logic [AW-1:0]  top_idx, wr_idx;
  logic           wr_en, err_set;

  assign STACK_EMPTY = (sp == '0);
  assign STACK_FULL  = (sp == SP_MAX);

  // DEPTH is a power of two, so the low AW bits of sp minus one give sp-1.
  // This also holds at sp==DEPTH, where those low bits wrap to 0.
  assign top_idx   = sp[AW-1:0] - AW'(1);
  // An empty stack reads 0, so unwritten entries are never exposed.
  assign STACK_TOP = STACK_EMPTY ? '0 : mem[top_idx];

  always_comb begin
    sp_nxt  = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[AW-1:0];
    err_set = 1'b0;
    case ({PUSH, POP})
      2'b10: begin
        if (!STACK_FULL) begin
          wr_en  = 1'b1;
          sp_nxt = sp + SPW'(1);
        end else begin
          err_set = 1'b1;
        end
      end
      2'b01: begin
        if (!STACK_EMPTY) sp_nxt = sp - SPW'(1);
        else              err_set = 1'b1;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (!STACK_EMPTY) begin
          // Replace the top in place: the pop and the push cancel out.
          wr_idx = top_idx;
        end else begin
          // Nothing to pop, so the push still lands and the pop is flagged.
          wr_idx  = '0;
          sp_nxt  = SPW'(1);
          err_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PC_COUNT  <= '0;
      sp        <= '0;
      STACK_ERR <= 1'b0;
    end else begin
      if (PC_LD)       PC_COUNT <= D_IN;
      else if (PC_INC) PC_COUNT <= PC_COUNT + n'(1);
      sp <= sp_nxt;
      if (err_set) STACK_ERR <= 1'b1;
    end
  end

  // The value pushed is the pre-edge PC. Reset blocks the write.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem[wr_idx] <= PC_COUNT;
  end

endmodule

// File: tb/tb_pc_ret_stack.sv
module tb_pc_ret_stack;
  localparam int N = 10;

  logic         CLK = 1'b0;
  logic         RST, PC_LD, PC_INC, PUSH, POP;
  logic [N-1:0] D_IN, PC_COUNT, STACK_TOP;
  logic         STACK_EMPTY, STACK_FULL, STACK_ERR;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic         rst, ld, inc, push, pop, fb;
    logic [N-1:0] d;
  } stim_t;

  typedef struct packed {
    logic [N-1:0] pc, top;
    logic         empty, full, err;
  } obs_t;

  obs_t exp_q[$];

  pc_ret_stack #(.n(N), .DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .D_IN(D_IN), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .PUSH(PUSH), .POP(POP), .PC_COUNT(PC_COUNT), .STACK_TOP(STACK_TOP),
    .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL), .STACK_ERR(STACK_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic stim_t mk(input logic rst, input logic ld, input logic inc,
                               input logic push, input logic pop, input logic fb,
                               input logic [N-1:0] d);
    mk = '{rst, ld, inc, push, pop, fb, d};
  endfunction

  function automatic obs_t ex(input logic [N-1:0] pc, input logic [N-1:0] top,
                              input logic empty, input logic full, input logic err);
    ex = '{pc, top, empty, full, err};
  endfunction

  function automatic obs_t observe();
    observe = '{PC_COUNT, STACK_TOP, STACK_EMPTY, STACK_FULL, STACK_ERR};
  endfunction

  function automatic string fmt(input obs_t o);
    fmt = $sformatf("pc=%h top=%h empty=%b full=%b err=%b",
                    o.pc, o.top, o.empty, o.full, o.err);
  endfunction

  // fb models the mux selecting FROM_STACK: D_IN follows STACK_TOP.
  task automatic drive(input stim_t s);
    RST = s.rst; PC_LD = s.ld; PC_INC = s.inc; PUSH = s.push; POP = s.pop;
    D_IN = s.fb ? STACK_TOP : s.d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    drive(mk(1, 1, 1, 1, 1, 0, 10'h155));
    exp_q.push_back(ex(0, 0, 1, 0, 0));
    tick();
    e = exp_q.pop_front(); g = observe(); checks++;
    if (g !== e) begin
      failures++; $display("FAIL reset got %s want %s", fmt(g), fmt(e));
    end
  endtask

  task automatic test_inc();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0)); x.push_back(ex(0, 0, 1, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      s.push_back(mk(0, 0, 1, 0, 0, 0, 0)); x.push_back(ex(N'(i), 0, 1, 0, 0));
    end
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL inc[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_call_ret();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 10'h005)); x.push_back(ex(10'h005, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 10'h120)); x.push_back(ex(10'h120, 10'h005, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 1, 1, 0));      x.push_back(ex(10'h005, 0, 1, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL call_ret[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_nested();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 10'h010)); x.push_back(ex(10'h010, 0, 1, 0, 0));
    // Each CALL saves the current PC and jumps to the next address.
    for (int i = 0; i < 8; i++) begin
      s.push_back(mk(0, 1, 0, 1, 0, 0, N'(10'h011 + i)));
      x.push_back(ex(N'(10'h011 + i), N'(10'h010 + i), 0, i == 7, 0));
    end
    s.push_back(mk(0, 0, 0, 1, 0, 0, 0)); x.push_back(ex(10'h018, 10'h017, 0, 1, 1));
    for (int k = 0; k < 8; k++) begin
      s.push_back(mk(0, 1, 0, 0, 1, 1, 0));
      x.push_back(ex(N'(10'h017 - k), (k < 7) ? N'(10'h016 - k) : N'(0), k == 7, 0, 1));
    end
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL nested[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_underflow();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0));      x.push_back(ex(0, 0, 1, 0, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 10'h033)); x.push_back(ex(10'h033, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 0, 0));      x.push_back(ex(10'h033, 10'h033, 0, 0, 1));
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0));      x.push_back(ex(10'h033, 0, 1, 0, 1));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL underflow[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_replace_wrap();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 10'h001)); x.push_back(ex(10'h001, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 10'h002)); x.push_back(ex(10'h002, 10'h001, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 10'h0AA)); x.push_back(ex(10'h0AA, 10'h002, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 0, 0));      x.push_back(ex(10'h0AA, 10'h0AA, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0));      x.push_back(ex(10'h0AA, 10'h001, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0));      x.push_back(ex(10'h0AA, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 10'h3FF)); x.push_back(ex(10'h3FF, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 0, 0, 0));      x.push_back(ex(10'h000, 0, 1, 0, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 0, 10'h200)); x.push_back(ex(10'h200, 0, 1, 0, 0));
    // Stack and PC updates in the same edge.
    s.push_back(mk(0, 0, 1, 1, 0, 0, 0));      x.push_back(ex(10'h201, 10'h200, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 0, 1, 0, 0));      x.push_back(ex(10'h202, 0, 1, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL replace_wrap[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$]; obs_t x[$]; obs_t e, g;
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 0, 0));      x.push_back(ex(0, 0, 1, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 10'h001)); x.push_back(ex(10'h001, 0, 1, 0, 1));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 10'h002)); x.push_back(ex(10'h002, 10'h001, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 10'h003)); x.push_back(ex(10'h003, 10'h002, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 10'h004)); x.push_back(ex(10'h004, 10'h003, 0, 0, 1));
    s.push_back(mk(1, 1, 0, 1, 0, 0, 10'h155)); x.push_back(ex(0, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0));      x.push_back(ex(0, 0, 1, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); g = observe(); checks++;
      if (g !== e) begin
        failures++; $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  initial begin
    RST = 1'b1; PC_LD = 1'b0; PC_INC = 1'b0; PUSH = 1'b0; POP = 1'b0; D_IN = '0;
    #1;
    test_reset();
    test_inc();
    test_call_ret();
    test_nested();
    test_underflow();
    test_replace_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
